// File: rtl/test_result_monitor.sv
// test_result_monitor: end-of-test detector shadowing the CPU write-back
// port; reports PASS/FAIL from a stable signature, or TIMEOUT.
module test_result_monitor #(
   parameter int unsigned       SIG_REG        = 17,
   parameter int unsigned       NUM_REG        = 10,
   parameter logic [31:0]       PASS_SIG       = 32'h0D000721,
   parameter logic [31:0]       FAIL_SIG       = 32'h01919810,
   parameter int unsigned       CONFIRM_CYCLES = 3,
   parameter int unsigned       TIMEOUT_CYCLES = 10000,
   parameter int unsigned       CNT_WIDTH      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wb_en,
   input  logic [4:0]           wb_rd,
   input  logic [31:0]          wb_data,
   output logic                 done,
   output logic                 pass,
   output logic                 fail,
   output logic                 timeout,
   output logic [31:0]          fail_num,
   output logic [CNT_WIDTH-1:0] cycle_count
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      CONFIRM = 2'd1,
      DONE    = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      V_NONE = 2'd0,
      V_PASS = 2'd1,
      V_FAIL = 2'd2,
      V_TMO  = 2'd3
   } verdict_t;

   localparam logic [4:0] SIG_IDX = SIG_REG[4:0];
   localparam logic [4:0] NUM_IDX = NUM_REG[4:0];
   localparam logic [7:0] CONF_LAST = 8'(CONFIRM_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] TMO_LAST =
      CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam bit ONE_SHOT = (CONFIRM_CYCLES == 1);

   state_t                 state, state_nx;
   verdict_t               verdict, verdict_nx;
   logic [31:0]            sig_q, num_q;
   logic [31:0]            num_lat, num_nx;
   logic [7:0]             confirm_cnt, confirm_nx;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_nx;
   logic                   match, sig_wr, sig_hit, wr_ok;

   assign wr_ok  = wb_en && (wb_rd != 5'd0);
   assign sig_wr = wb_en && (wb_rd == SIG_IDX);
   assign match  = (sig_q == PASS_SIG) || (sig_q == FAIL_SIG);

   // Shadow copies of the signature and test-number registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q <= '0;
         num_q <= '0;
      end else if (wr_ok) begin
         if (wb_rd == SIG_IDX) sig_q <= wb_data;
         if (wb_rd == NUM_IDX) num_q <= wb_data;
      end
   end

   // State register plus verdict, latched test number and counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         verdict     <= V_NONE;
         num_lat     <= '0;
         confirm_cnt <= '0;
         cnt_q       <= '0;
      end else begin
         state       <= state_nx;
         verdict     <= verdict_nx;
         num_lat     <= num_nx;
         confirm_cnt <= confirm_nx;
         cnt_q       <= cnt_nx;
      end
   end

   // Next state: stability tracking, then signature/timeout arbitration
   always_comb begin
      state_nx   = state;
      verdict_nx = verdict;
      num_nx     = num_lat;
      confirm_nx = confirm_cnt;
      cnt_nx     = cnt_q;
      sig_hit    = 1'b0;
      case (state)
         RUN: begin
            if (match && !sig_wr) begin
               if (ONE_SHOT) begin
                  sig_hit = 1'b1;
               end else begin
                  state_nx   = CONFIRM;
                  confirm_nx = 8'd1;
               end
            end
         end
         CONFIRM: begin
            if (sig_wr || !match) begin
               state_nx   = RUN;
               confirm_nx = '0;
            end else if (confirm_cnt == CONF_LAST) begin
               sig_hit = 1'b1;
            end else begin
               confirm_nx = confirm_cnt + 8'd1;
            end
         end
         default: ;
      endcase
      if (state != DONE) begin
         cnt_nx = cnt_q + 1'b1;
         // A signature confirmed on the timeout edge still wins
         if (sig_hit) begin
            state_nx   = DONE;
            confirm_nx = '0;
            num_nx     = num_q;
            verdict_nx = (sig_q == PASS_SIG) ? V_PASS : V_FAIL;
         end else if (cnt_q == TMO_LAST) begin
            state_nx   = DONE;
            confirm_nx = '0;
            num_nx     = num_q;
            verdict_nx = V_TMO;
            cnt_nx     = cnt_q;
         end
      end
   end

   // Outputs decoded from state and the latched verdict
   always_comb begin
      done        = (state == DONE);
      pass        = (verdict == V_PASS);
      fail        = (verdict == V_FAIL);
      timeout     = (verdict == V_TMO);
      fail_num    = num_lat;
      cycle_count = cnt_q;
   end

endmodule
